// File: rtl/rr_mux_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rr_mux_scheduler
// Purpose  : Round-robin arbiter over N valid/ready source channels feeding a
//            single-entry registered N:1 output stage with valid/ready
//            handshake. Grants rotate fairly from a priority pointer that
//            advances past each captured winner.
// Ports    : clk        - rising-edge clock
//            rst_n      - synchronous active-low reset
//            in_valid   - per-channel request (bit i = channel i)
//            in_data    - channel i data at [i*W+W-1 : i*W]
//            in_ready   - per-channel accept, at most one bit high
//            out_valid  - output register holds a word
//            out_data   - registered winning data
//            out_sel    - index of the channel that supplied out_data
//            out_grant  - one-hot of out_sel, zero while out_valid=0
//            out_ready  - downstream accepts the held word
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module rr_mux_scheduler #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int SELW = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    in_valid,
   input  logic [N*W-1:0]  in_data,
   output logic [N-1:0]    in_ready,
   output logic            out_valid,
   output logic [W-1:0]    out_data,
   output logic [SELW-1:0] out_sel,
   output logic [N-1:0]    out_grant,
   input  logic            out_ready
);

   localparam logic [SELW-1:0] c_last_idx = SELW'(N - 1);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t          r_state;
   logic [SELW-1:0] r_ptr;
   logic [W-1:0]    r_data;
   logic [SELW-1:0] r_sel;
   logic [N-1:0]    r_grant;

   logic [N-1:0]    w_masked;
   logic            w_found_hi;
   logic            w_found;
   logic [SELW-1:0] w_win;
   logic [N-1:0]    w_win_oh;
   logic [W-1:0]    w_win_data;
   logic            w_load;
   logic            w_capture;

   // Two-pass priority search: first the requests at or above the pointer,
   // and only if none exist, the requests below it. This is equivalent to a
   // search starting at ptr that wraps modulo N, without modulo arithmetic.
   always_comb begin
      w_masked   = '0;
      w_found_hi = 1'b0;
      w_found    = 1'b0;
      w_win      = '0;
      for (int i = 0; i < N; i++) begin
         w_masked[i] = in_valid[i] && (i >= int'(r_ptr));
      end
      // Descending loops leave the lowest qualifying index in w_win.
      for (int i = N - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            w_found = 1'b1;
            w_win   = SELW'(i);
         end
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (w_masked[i]) begin
            w_found_hi = 1'b1;
            w_win      = SELW'(i);
         end
      end
      // w_found_hi implies w_found; kept for readability of the search.
      if (w_found_hi) begin
         w_found = 1'b1;
      end
   end

   always_comb begin
      w_win_oh   = '0;
      w_win_data = '0;
      for (int i = 0; i < N; i++) begin
         w_win_oh[i] = w_found && (w_win == SELW'(i));
         w_win_data  = w_win_data | (in_data[i*W +: W] & {W{w_win_oh[i]}});
      end
   end

   assign w_load    = (r_state == ST_EMPTY) || out_ready;
   assign w_capture = w_load && w_found;

   // Reset gating keeps sources from seeing an accept on a reset cycle.
   assign in_ready  = (rst_n && w_load) ? w_win_oh : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_ptr   <= '0;
         r_data  <= '0;
         r_sel   <= '0;
         r_grant <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_capture) begin
                  r_state <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (out_ready && !w_found) begin
                  // Drained with nothing to replace it; data/sel keep last value.
                  r_state <= ST_EMPTY;
                  r_grant <= '0;
               end
            end
            default: begin
               r_state <= ST_EMPTY;
            end
         endcase

         if (w_capture) begin
            r_data  <= w_win_data;
            r_sel   <= w_win;
            r_grant <= w_win_oh;
            r_ptr   <= (w_win == c_last_idx) ? '0 : (w_win + 1'b1);
         end
      end
   end

   assign out_valid = (r_state == ST_FULL);
   assign out_data  = r_data;
   assign out_sel   = r_sel;
   assign out_grant = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_rr_mux_scheduler
// Purpose  : Directed self-checking bench for rr_mux_scheduler (N=4, W=8).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_rr_mux_scheduler;

   localparam int N    = 4;
   localparam int W    = 8;
   localparam int SELW = 2;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    in_valid;
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic [W-1:0]    out_data;
   logic [SELW-1:0] out_sel;
   logic [N-1:0]    out_grant;
   logic            out_ready;

   int n_checks;
   int n_fail;

   rr_mux_scheduler #(
      .N    (N),
      .W    (W),
      .SELW (SELW)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_grant (out_grant),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [SELW-1:0] sel,
                             input logic [W-1:0] data, input logic [N-1:0] grant);
      check_eq({tag, ".valid"}, 32'(out_valid), 32'(v));
      check_eq({tag, ".sel"},   32'(out_sel),   32'(sel));
      check_eq({tag, ".data"},  32'(out_data),  32'(data));
      check_eq({tag, ".grant"}, 32'(out_grant), 32'(grant));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ramp_data();
      for (int i = 0; i < N; i++) begin
         in_data[i*W +: W] = 8'(8'h10 + i);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      in_data   = '0;
      set_ramp_data();

      // Reset held 3 cycles with every channel requesting.
      for (int c = 0; c < 3; c++) begin
         tick();
         check_eq("rst.valid", 32'(out_valid), 32'd0);
         check_eq("rst.grant", 32'(out_grant), 32'd0);
         check_eq("rst.in_ready", 32'(in_ready), 32'd0);
      end
      check_eq("rst.data", 32'(out_data), 32'd0);
      check_eq("rst.sel", 32'(out_sel), 32'd0);

      // Release: channel 0 wins first, then strict rotation with no bubbles.
      rst_n = 1'b1;
      #1;
      check_eq("rel.in_ready", 32'(in_ready), 32'b0001);
      for (int k = 0; k < 8; k++) begin
         tick();
         expect_out("rot", 1'b1, SELW'(k % 4), 8'(8'h10 + (k % 4)), 4'(1 << (k % 4)));
      end

      // Single channel 2 with A5; pointer was back at 0.
      in_valid = 4'b0100;
      in_data[2*W +: W] = 8'hA5;
      #1;
      check_eq("single.in_ready", 32'(in_ready), 32'b0100);
      tick();
      expect_out("single", 1'b1, 2'd2, 8'hA5, 4'b0100);

      // Drain to EMPTY: grant clears, data/sel keep last value.
      in_valid = 4'b0000;
      tick();
      expect_out("drain", 1'b0, 2'd2, 8'hA5, 4'b0000);

      // Wrap and skip: ptr=3, channels 0 and 1 requesting.
      in_valid = 4'b0011;
      in_data[0*W +: W] = 8'h20;
      in_data[1*W +: W] = 8'h21;
      #1;
      check_eq("wrap.in_ready0", 32'(in_ready), 32'b0001);
      tick();
      expect_out("wrap0", 1'b1, 2'd0, 8'h20, 4'b0001);
      check_eq("wrap.in_ready1", 32'(in_ready), 32'b0010);
      tick();
      expect_out("wrap1", 1'b1, 2'd1, 8'h21, 4'b0010);
      in_valid = 4'b0000;
      tick();
      check_eq("wrap.empty", 32'(out_valid), 32'd0);

      // Backpressure: load 11 from channel 1 (ptr=2 so channel 1 is reached by wrap).
      set_ramp_data();
      in_valid = 4'b0010;
      tick();
      expect_out("bp.load", 1'b1, 2'd1, 8'h11, 4'b0010);
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         check_eq("bp.in_ready", 32'(in_ready), 32'd0);
         tick();
         expect_out("bp.hold", 1'b1, 2'd1, 8'h11, 4'b0010);
      end
      out_ready = 1'b1;
      #1;
      check_eq("bp.release.in_ready", 32'(in_ready), 32'b0100);
      tick();
      expect_out("bp.b2b", 1'b1, 2'd2, 8'h12, 4'b0100);

      // Reset mid-operation while FULL and stalled: held word lost, ptr back to 0.
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      check_eq("mid.rst.in_ready", 32'(in_ready), 32'd0);
      tick();
      expect_out("mid.rst", 1'b0, 2'd0, 8'h00, 4'b0000);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      check_eq("mid.rel.in_ready", 32'(in_ready), 32'b0001);
      tick();
      expect_out("mid.first", 1'b1, 2'd0, 8'h10, 4'b0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rr_mux_scheduler.md
Name: rr_mux_scheduler

Overview:
- Round-robin scheduler and registered N:1 data multiplexer placed directly upstream of the team's 2x1/Nx1 mux datapath.
- Arbitrates among N valid/ready source channels and drives a select index plus a one-hot grant.
- Registers the winning word into a single-entry output stage with a valid/ready handshake.
- Converts the combinational select-driven mux into a fair, flow-controlled sequential stage.

Parameters:
- N, 4, number of source channels (2..16)
- W, 8, data width per channel in bits
- SELW, 2, select width; must equal ceil(log2(N)), minimum 1

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  N  per-channel request; bit i belongs to channel i
- in_data  input  N*W  channel i data occupies bits [i*W+W-1 : i*W]
- in_ready  output  N  per-channel accept; at most one bit high per cycle
- out_valid  output  1  output register holds a valid word
- out_data  output  W  registered winning data
- out_sel  output  SELW  index of the channel that supplied out_data
- out_grant  output  N  one-hot form of out_sel; all-zero when out_valid=0
- out_ready  input  1  downstream accepts the word when out_valid=1

Behaviour:
- Reset: sampled on the rising clk edge with rst_n=0. Sets out_valid=0, out_data=0, out_sel=0, out_grant=0, and priority pointer ptr=0. in_ready is combinationally 0 while rst_n=0.
- Reset mid-transfer discards the held word. No handshake completes on the reset cycle.
- Load condition: load = ~out_valid | out_ready.
- Arbitration (combinational):
  - Search channels starting at ptr, then ptr+1, and so on, wrapping modulo N.
  - The first i with in_valid[i]=1 wins.
  - in_ready[win]=load; all other in_ready bits are 0.
  - Sources must hold in_valid and in_data stable until in_ready is seen. The block does not require this, but a dropped request is simply not served.
- State machine, 2 states:
  - EMPTY (out_valid=0):
    - If any in_valid, capture the winner next edge and go to FULL.
    - Otherwise stay in EMPTY.
  - FULL (out_valid=1):
    - out_ready=0: hold out_data, out_sel and out_grant unchanged and stay in FULL. All in_ready are 0.
    - out_ready=1 with any in_valid: capture the new winner in the same edge (back-to-back) and stay in FULL.
    - out_ready=1 with no in_valid: clear out_valid and out_grant, go to EMPTY. out_data and out_sel keep their last value.
- Capture edge actions:
  - out_data <= in_data of the winner; out_sel <= winner index; out_grant <= 1<<winner.
  - ptr <= (winner+1) mod N.
  - ptr changes only on a capture.
- Latency and throughput:
  - Accept to out_valid is 1 cycle.
  - Sustained throughput is 1 word/cycle while out_ready=1.
- Fairness: with all channels requesting continuously, grants rotate 0,1,..,N-1,0. No channel waits more than N-1 captures.
- Wrap-around: when the winner is N-1, ptr wraps to 0. A non-power-of-2 N never produces an index >= N.
- Simultaneous events: a consume and a new capture on the same edge is one transfer out and one in, with no bubble. Rule: out_valid stays 1.
- No combinational path exists from out_ready to out_data. The path out_ready -> in_ready is combinational and permitted.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all in_valid=1 -> out_valid=0, out_grant=0000, in_ready=0000. First capture after release is channel 0.
- Single channel, N=4, W=8: in_valid=0100, in_data[2]=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=A5, out_sel=2, out_grant=0100, ptr=3.
- All request, out_ready=1, data[i]=8'h10+i for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with out_data 10,11,12,13,10..., no bubbles.
- Backpressure: FULL holding 8'h11 with out_ready=0 for 4 cycles -> out_data stays 11, in_ready=0000. Raise out_ready -> 11 consumed and next winner captured on the same edge.
- Wrap and skip: ptr=3, in_valid=0011 -> winner channel 0, then channel 1 on the next capture.
- Reset mid-operation: FULL state with out_ready=0, assert rst_n=0 for 1 cycle -> out_valid=0, ptr=0, held word lost.
